// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: valid/ready handshake, optional 2-entry
// skid buffer, bubble control-clearing, flush, and a saturating stall counter.
module pipe_stage_reg #(
    parameter int DATA_W   = 64,
    parameter int CTRL_W   = 16,
    parameter int SKID     = 1,
    parameter int CLR_DATA = 0,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
    // out_* is stable while out_valid & ~out_ready; in_ready never depends on in_valid.

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q;
    logic [CNT_W-1:0]  stall_q;
    logic              in_xfer, out_xfer;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    // Bubbles never leak control bits; data is cleared too when CLR_DATA is set.
    assign out_ctrl     = out_valid ? main_ctrl_q : '0;
    assign out_data     = (CLR_DATA != 0 && !out_valid) ? '0 : main_data_q;
    assign occupancy    = state_q;
    assign stall_cycles = stall_q;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d     = ONE;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (in_xfer) begin
                        state_d     = TWO;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        state_d     = ONE;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= (state_d != TWO);
        end
    end

    // Stall counter survives flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && stall_q != {CNT_W{1'b1}}) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: skid-buffered default stage plus a SKID=0, CLR_DATA=1, CNT_W=4 stage.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Skid-buffered instance, default widths
    logic        a_rst_n, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [63:0] a_in_data, a_out_data;
    logic [15:0] a_in_ctrl, a_out_ctrl;
    logic [1:0]  a_occ;
    logic [31:0] a_stall;

    pipe_stage_reg u_dut_a (
        .clk(clk), .rst_n(a_rst_n), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
        .occupancy(a_occ), .stall_cycles(a_stall)
    );

    // Single-entry instance with data clearing and a 4-bit counter
    logic       b_rst_n, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0] b_in_data, b_out_data;
    logic [3:0] b_in_ctrl, b_out_ctrl;
    logic [1:0] b_occ;
    logic [3:0] b_stall;

    pipe_stage_reg #(.DATA_W(8), .CTRL_W(4), .SKID(0), .CLR_DATA(1), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(b_rst_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
        .occupancy(b_occ), .stall_cycles(b_stall)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        a_rst_n = 1'b0; a_flush = 1'b0; a_in_valid = 1'b1; a_out_ready = 1'b1;
        a_in_data = 64'h1000; a_in_ctrl = 16'h0001;
        b_rst_n = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        b_in_data = 8'h00; b_in_ctrl = 4'h0;

        // Reset held 3 cycles with in_valid asserted
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_out_valid", 64'(a_out_valid), 64'd0);
            check("rst_out_ctrl", 64'(a_out_ctrl), 64'd0);
        end
        check("rst_out_data", a_out_data, 64'd0);
        check("rst_occ", 64'(a_occ), 64'd0);
        check("rst_stall", 64'(a_stall), 64'd0);
        check("rst_in_ready", 64'(a_in_ready), 64'd1);

        // Stream three entries at full rate
        a_rst_n = 1'b1;
        tick();
        check("s0_valid", 64'(a_out_valid), 64'd1);
        check("s0_data", a_out_data, 64'h1000);
        check("s0_ctrl", 64'(a_out_ctrl), 64'h0001);
        a_in_data = 64'h1004; a_in_ctrl = 16'h0002;
        check("s0_in_ready", 64'(a_in_ready), 64'd1);
        tick();
        check("s1_data", a_out_data, 64'h1004);
        check("s1_ctrl", 64'(a_out_ctrl), 64'h0002);
        a_in_data = 64'h1008; a_in_ctrl = 16'h0003;
        tick();
        check("s2_data", a_out_data, 64'h1008);
        check("s2_occ", 64'(a_occ), 64'd1);
        a_in_valid = 1'b0;
        tick();
        check("drain_valid", 64'(a_out_valid), 64'd0);
        check("drain_ctrl", 64'(a_out_ctrl), 64'd0);
        check("drain_stall", 64'(a_stall), 64'd0);

        // Backpressure: fill main and skid
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 64'h10; a_in_ctrl = 16'h000A;
        tick();
        check("bp_a_occ", 64'(a_occ), 64'd1);
        a_in_data = 64'h20; a_in_ctrl = 16'h000B;
        tick();
        a_in_valid = 1'b0;
        check("bp_occ2", 64'(a_occ), 64'd2);
        check("bp_in_ready0", 64'(a_in_ready), 64'd0);
        check("bp_hold_data", a_out_data, 64'h10);
        check("bp_stall1", 64'(a_stall), 64'd1);
        tick();
        check("bp_stall2", 64'(a_stall), 64'd2);
        check("bp_hold_data2", a_out_data, 64'h10);
        tick();
        check("bp_stall3", 64'(a_stall), 64'd3);
        a_out_ready = 1'b1;
        tick();
        check("bp_b_data", a_out_data, 64'h20);
        check("bp_b_ctrl", 64'(a_out_ctrl), 64'h000B);
        check("bp_in_ready1", 64'(a_in_ready), 64'd1);
        check("bp_occ1", 64'(a_occ), 64'd1);
        tick();
        check("bp_empty", 64'(a_out_valid), 64'd0);
        check("bp_stall_kept", 64'(a_stall), 64'd3);

        // Flush with skid full
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 64'h40; a_in_ctrl = 16'h0001;
        tick();
        a_in_data = 64'h50; a_in_ctrl = 16'h0002;
        tick();
        check("fl_occ2", 64'(a_occ), 64'd2);
        a_flush = 1'b1; a_in_data = 64'hDEAD; a_in_ctrl = 16'hFFFF;
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        check("fl_valid", 64'(a_out_valid), 64'd0);
        check("fl_ctrl", 64'(a_out_ctrl), 64'd0);
        check("fl_occ", 64'(a_occ), 64'd0);
        check("fl_in_ready", 64'(a_in_ready), 64'd1);
        check("fl_data_held", a_out_data, 64'h40);
        check("fl_stall", 64'(a_stall), 64'd5);
        a_out_ready = 1'b1;
        tick();
        check("fl_no_ghost", 64'(a_out_valid), 64'd0);

        // Flush coinciding with an output transfer
        a_in_valid = 1'b1; a_in_data = 64'h60; a_in_ctrl = 16'h0003;
        tick();
        a_flush = 1'b1; a_in_data = 64'h70; a_in_ctrl = 16'h0004;
        check("fo_presented_valid", 64'(a_out_valid && a_out_ready), 64'd1);
        check("fo_presented_data", a_out_data, 64'h60);
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        check("fo_empty", 64'(a_out_valid), 64'd0);
        check("fo_occ", 64'(a_occ), 64'd0);
        tick();
        check("fo_no_ghost", 64'(a_out_valid), 64'd0);
        check("fo_stall", 64'(a_stall), 64'd5);

        // Reset mid-operation drops the entry
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 64'h80; a_in_ctrl = 16'h0005;
        tick();
        a_in_valid = 1'b0; a_rst_n = 1'b0;
        tick();
        a_rst_n = 1'b1;
        check("mr_occ", 64'(a_occ), 64'd0);
        check("mr_valid", 64'(a_out_valid), 64'd0);
        check("mr_stall", 64'(a_stall), 64'd0);
        check("mr_data", a_out_data, 64'd0);

        // SKID=0 pass-through and combinational in_ready
        b_rst_n = 1'b1; b_out_ready = 1'b1;
        #1;
        check("b_idle_in_ready", 64'(b_in_ready), 64'd1);
        b_in_valid = 1'b1; b_in_data = 8'h11; b_in_ctrl = 4'h5;
        tick();
        check("b_first_data", 64'(b_out_data), 64'h11);
        b_in_data = 8'h22; b_in_ctrl = 4'h6;
        #1;
        check("b_pass_in_ready", 64'(b_in_ready), 64'd1);
        tick();
        check("b_replaced_data", 64'(b_out_data), 64'h22);
        check("b_replaced_ctrl", 64'(b_out_ctrl), 64'h6);
        b_out_ready = 1'b0; b_in_data = 8'h33;
        #1;
        check("b_block_in_ready", 64'(b_in_ready), 64'd0);
        tick();
        b_in_valid = 1'b0;
        check("b_not_taken", 64'(b_out_data), 64'h22);
        check("b_stall1", 64'(b_stall), 64'd1);

        // Counter saturation, flush-immune, reset-cleared
        for (int i = 0; i < 20; i++) tick();
        check("b_sat", 64'(b_stall), 64'd15);
        check("b_sat_data", 64'(b_out_data), 64'h22);
        b_flush = 1'b1;
        tick();
        b_flush = 1'b0;
        check("b_fl_stall", 64'(b_stall), 64'd15);
        check("b_fl_valid", 64'(b_out_valid), 64'd0);
        check("b_fl_data_zero", 64'(b_out_data), 64'd0);
        check("b_fl_ctrl", 64'(b_out_ctrl), 64'd0);
        check("b_fl_in_ready", 64'(b_in_ready), 64'd1);
        b_rst_n = 1'b0;
        tick();
        b_rst_n = 1'b1;
        check("b_rst_stall", 64'(b_stall), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
